// File: rtl/cpu_phase_controller.sv
// Eight-phase fetch/execute sequencer for the 8-bit CPU: phase counter, sticky halt,
// retired-instruction counter and the per-phase control strobes decoded from opcode and Zero.
//
// state      | meaning
// INST_ADDR  | PC drives the memory address
// INST_FETCH | instruction read from memory
// INST_LOAD  | instruction register loads
// IDLE       | instruction register holds its load
// OP_ADDR    | PC increments, or the halt is taken on HLT
// OP_FETCH   | operand read for ALU instructions
// ALU_OP     | operand presented to ALU; SKZ skip, JMP load, STO drive
// STORE      | accumulator load, memory write or jump completes
module cpu_phase_controller #(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [2:0]       Opcode,
    input  logic             Zero,
    output logic [2:0]       Phase,
    output logic             Sel,
    output logic             Rd,
    output logic             Ld_ir,
    output logic             Inc_pc,
    output logic             Ld_pc,
    output logic             Ld_ac,
    output logic             Wr,
    output logic             Data_e,
    output logic             Halted,
    output logic [CNT_W-1:0] Instr_cnt
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    phase_t phase_q;
    logic   alu_op;
    logic   take_halt;

    assign Phase     = phase_q;
    assign alu_op    = (Opcode == OP_ADD) || (Opcode == OP_AND) ||
                       (Opcode == OP_XOR) || (Opcode == OP_LDA);
    assign take_halt = (phase_q == OP_ADDR) && (Opcode == OP_HLT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            phase_q   <= INST_ADDR;
            Halted    <= 1'b0;
            Instr_cnt <= '0;
        end else if (Run && !Halted) begin
            if (take_halt) begin
                Halted <= 1'b1;
            end else begin
                phase_q <= phase_t'(phase_q + 3'd1);
                if (phase_q == STORE) begin
                    Instr_cnt <= Instr_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Reset forces the PC onto the address bus even while Run is low.
    always_comb begin
        Sel    = 1'b0;
        Rd     = 1'b0;
        Ld_ir  = 1'b0;
        Inc_pc = 1'b0;
        Ld_pc  = 1'b0;
        Ld_ac  = 1'b0;
        Wr     = 1'b0;
        Data_e = 1'b0;
        if (Reset) begin
            Sel = 1'b1;
        end else if (Run && !Halted) begin
            case (phase_q)
                INST_ADDR: begin
                    Sel = 1'b1;
                end
                INST_FETCH: begin
                    Sel = 1'b1;
                    Rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    Sel   = 1'b1;
                    Rd    = 1'b1;
                    Ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    Inc_pc = (Opcode != OP_HLT);
                end
                OP_FETCH: begin
                    Rd = alu_op;
                end
                ALU_OP: begin
                    Rd     = alu_op;
                    Inc_pc = (Opcode == OP_SKZ) && Zero;
                    Ld_pc  = (Opcode == OP_JMP);
                    Data_e = (Opcode == OP_STO);
                end
                STORE: begin
                    Rd     = alu_op;
                    Ld_ac  = alu_op;
                    Ld_pc  = (Opcode == OP_JMP);
                    Wr     = (Opcode == OP_STO);
                    Data_e = (Opcode == OP_STO);
                end
                default: begin
                    Sel = 1'b0;
                end
            endcase
        end
    end

endmodule
